// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared definitions for the RAM port arbiter between the CPU memory stage
// and the host burst port:
//   V, AW, BE, LW  - data width, word-address width, byte-enable width and
//                    burst-length field width
//   BE_ALL_ONES    - byte enable used for every host write beat
//   arb_state_e    - arbiter FSM states
package mem_arb_pkg;

  localparam int V  = 256;
  localparam int AW = 14;
  localparam int BE = V / 8;
  localparam int LW = 4;

  localparam logic [BE-1:0] BE_ALL_ONES = {BE{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOST_WR = 2'd1,
    HOST_RD = 2'd2,
    DONE    = 2'd3
  } arb_state_e;

endpackage

// File: rtl/burst_addr_gen.sv
// burst_addr_gen
// Address and beat counter for one host burst.
//   clk, rst  - clock, synchronous active-high reset
//   load      - capture base address and length (beats minus 1)
//   advance   - step to the next beat
//   base, len - burst start address and beats-minus-1
//   addr      - address of the current beat (wraps modulo 2^AW)
//   last      - current beat is the final one of the burst
module burst_addr_gen
  import mem_arb_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          advance,
  input  logic [AW-1:0] base,
  input  logic [LW-1:0] len,
  output logic [AW-1:0] addr,
  output logic          last
);

  logic [AW-1:0] addr_r;
  // Beats still to be issued, including the current one (1..2^LW).
  logic [LW:0]   remaining_r;

  // Burst address / remaining-beat counters; the address wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r      <= {AW{1'b0}};
      remaining_r <= {(LW+1){1'b0}};
    end else if (load) begin
      addr_r      <= base;
      remaining_r <= {1'b0, len} + {{LW{1'b0}}, 1'b1};
    end else if (advance) begin
      addr_r      <= addr_r + {{(AW-1){1'b0}}, 1'b1};
      remaining_r <= remaining_r - {{LW{1'b0}}, 1'b1};
    end else begin
      addr_r      <= addr_r;
      remaining_r <= remaining_r;
    end
  end

  assign addr = addr_r;
  assign last = (remaining_r == {{LW{1'b0}}, 1'b1});

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single port of the 256-bit byte-enabled ip_ram between the CPU
// memory stage (zero-latency pass-through) and a host burst port.
//   cpu_*        - CPU request from the aligner; cpu_readData back to it,
//                  cpu_stall into the hazard unit
//   host_req/we/address/len/wdata - host burst request, fields sampled at grant
//   host_grant   - host owns the port (burst beats and the DONE cycle)
//   host_ack     - write beat consumed this cycle
//   host_rdata/host_rvalid - read beat returned from the RAM
//   host_done    - one-cycle pulse closing a burst
//   ram_*        - RAM port; ram_q is the RAM's registered read data
// Reset is synchronous and also forces every output to zero while asserted,
// so a reset that lands on a burst beat stops that beat from being written.
module mem_port_arbiter
  import mem_arb_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_rden,
  input  logic          cpu_wren,
  input  logic [AW-1:0] cpu_address,
  input  logic [BE-1:0] cpu_byteena,
  input  logic [V-1:0]  cpu_writeData,
  output logic [V-1:0]  cpu_readData,
  output logic          cpu_stall,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_address,
  input  logic [LW-1:0] host_len,
  input  logic [V-1:0]  host_wdata,
  output logic          host_grant,
  output logic          host_ack,
  output logic [V-1:0]  host_rdata,
  output logic          host_rvalid,
  output logic          host_done,
  output logic          ram_rden,
  output logic          ram_wren,
  output logic [AW-1:0] ram_address,
  output logic [BE-1:0] ram_byteena,
  output logic [V-1:0]  ram_data,
  input  logic [V-1:0]  ram_q
);

  arb_state_e    state_r;
  arb_state_e    next_state_s;
  logic          start_s;
  logic          advance_s;
  logic [AW-1:0] burst_addr_s;
  logic          burst_last_s;
  // A read was issued last cycle, and whether the host (1) or CPU (0) issued it.
  logic          rd_valid_r;
  logic          owner_host_r;

  // The host only wins arbitration when the CPU has nothing to issue.
  assign start_s   = (state_r == IDLE) && host_req && !cpu_rden && !cpu_wren;
  assign advance_s = (state_r == HOST_WR) || (state_r == HOST_RD);

  burst_addr_gen u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (start_s),
    .advance (advance_s),
    .base    (host_address),
    .len     (host_len),
    .addr    (burst_addr_s),
    .last    (burst_last_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; DONE always returns to IDLE so the CPU gets a chance
  // at every arbitration between bursts.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          next_state_s = host_we ? HOST_WR : HOST_RD;
        end else begin
          next_state_s = IDLE;
        end
      end
      HOST_WR: begin
        if (burst_last_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = HOST_WR;
        end
      end
      HOST_RD: begin
        if (burst_last_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = HOST_RD;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // RAM port mux, grant/ack/done and CPU stall decode.
  always_comb begin
    ram_rden    = 1'b0;
    ram_wren    = 1'b0;
    ram_address = {AW{1'b0}};
    ram_byteena = {BE{1'b0}};
    ram_data    = {V{1'b0}};
    cpu_stall   = 1'b0;
    host_grant  = 1'b0;
    host_ack    = 1'b0;
    host_done   = 1'b0;
    if (!rst) begin
      case (state_r)
        IDLE: begin
          ram_rden    = cpu_rden;
          ram_wren    = cpu_wren;
          ram_address = cpu_address;
          ram_byteena = cpu_byteena;
          ram_data    = cpu_writeData;
        end
        HOST_WR: begin
          host_grant  = 1'b1;
          host_ack    = 1'b1;
          ram_wren    = 1'b1;
          ram_address = burst_addr_s;
          ram_byteena = BE_ALL_ONES;
          ram_data    = host_wdata;
          cpu_stall   = cpu_rden | cpu_wren;
        end
        HOST_RD: begin
          host_grant  = 1'b1;
          ram_rden    = 1'b1;
          ram_address = burst_addr_s;
          cpu_stall   = cpu_rden | cpu_wren;
        end
        DONE: begin
          host_grant  = 1'b1;
          host_done   = 1'b1;
          cpu_stall   = cpu_rden | cpu_wren;
        end
        default: begin
          host_grant  = 1'b0;
        end
      endcase
    end else begin
      host_grant = 1'b0;
    end
  end

  // Remember who issued this cycle's RAM read so next cycle's ram_q is routed.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_r   <= 1'b0;
      owner_host_r <= 1'b0;
    end else begin
      rd_valid_r   <= ram_rden;
      owner_host_r <= (state_r == HOST_RD);
    end
  end

  // Read-data return to whichever master owns last cycle's read.
  always_comb begin
    cpu_readData = {V{1'b0}};
    host_rdata   = {V{1'b0}};
    host_rvalid  = 1'b0;
    if (!rst && rd_valid_r) begin
      if (owner_host_r) begin
        host_rdata  = ram_q;
        host_rvalid = 1'b1;
      end else begin
        cpu_readData = ram_q;
      end
    end else begin
      host_rvalid = 1'b0;
    end
  end

endmodule
